// File: rtl/fpu_cvt_f2i_pipe.sv
// -----------------------------------------------------------------------------
// fpu_cvt_f2i_pipe
//   Two-stage elastic pipeline around an external combinational float-to-int
//   converter (FCVT.W.S / FCVT.WU.S).
//   Stage 1: captures the request, resolves the rounding mode (static or
//            dynamic frm) and classifies the operand (NaN / Inf / zero).
//   Stage 2: presents the operand to the converter through conv_*, overrides
//            special cases, computes NV/NX and holds the result until the
//            writeback arbiter takes it.
//
// Ports
//   clock, reset_n         rising-edge clock, asynchronous active-low reset
//   in_valid / in_ready    upstream handshake (FPU issue)
//   in_op                  IEEE-754 single operand
//   in_is_signed           1 = FCVT.W.S, 0 = FCVT.WU.S
//   in_rm                  instruction rm field, 3'b111 selects frm
//   in_tag                 destination register tag
//   frm                    CSR rounding mode, sampled on accept
//   conv_in/_is_signed/_rm operand, signedness and resolved rm to converter
//   conv_out               converter result (same cycle)
//   out_valid / out_ready  downstream handshake (writeback)
//   out_result, out_tag    integer result and its tag
//   out_fflags             {NV,DZ,OF,UF,NX}
//   out_illegal            resolved rm was reserved (101/110/111)
// -----------------------------------------------------------------------------
module fpu_cvt_f2i_pipe #(
  parameter int TAG_W = 5
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      in_op,
  input  logic             in_is_signed,
  input  logic [2:0]       in_rm,
  input  logic [TAG_W-1:0] in_tag,
  input  logic [2:0]       frm,
  output logic [31:0]      conv_in,
  output logic             conv_is_signed,
  output logic [2:0]       conv_rm,
  input  logic [31:0]      conv_out,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [31:0]      out_result,
  output logic [TAG_W-1:0] out_tag,
  output logic [4:0]       out_fflags,
  output logic             out_illegal
);

  // Handshake
  logic s1_valid, s2_valid;
  logic s1_adv, s2_adv, in_fire;

  assign s2_adv   = ~s2_valid | out_ready;
  assign s1_adv   = s1_valid & s2_adv;
  // Depends only on registered state and out_ready, never on in_valid.
  assign in_ready = ~s1_valid | s2_adv;
  assign in_fire  = in_valid & in_ready;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      s1_valid <= 1'b0;
      s2_valid <= 1'b0;
    end else begin
      // When in_ready is high, stage 1 is either empty or handing its entry on.
      if (in_ready) s1_valid <= in_valid;
      if (s2_adv)   s2_valid <= s1_valid;
    end
  end

  // Stage 1 capture
  logic [2:0] rm_res;
  assign rm_res = (in_rm == 3'b111) ? frm : in_rm;

  logic [31:0]      s1_op,  s2_op;
  logic             s1_signed, s2_signed;
  logic [2:0]       s1_rm,  s2_rm;
  logic [TAG_W-1:0] s1_tag, s2_tag;
  logic             s1_illegal, s2_illegal;
  logic             s1_nan, s2_nan;
  logic             s1_inf, s2_inf;
  logic             s1_zero, s2_zero;

  // NOTE: payload registers carry no reset; they are only observed when the
  // matching valid bit is set, and that bit is reset.
  always_ff @(posedge clock) begin
    if (in_fire) begin
      s1_op      <= in_op;
      s1_signed  <= in_is_signed;
      s1_rm      <= rm_res;
      s1_tag     <= in_tag;
      s1_illegal <= (rm_res == 3'b101) || (rm_res == 3'b110) || (rm_res == 3'b111);
      s1_nan     <= (in_op[30:23] == 8'hFF) && (in_op[22:0] != 23'd0);
      s1_inf     <= (in_op[30:23] == 8'hFF) && (in_op[22:0] == 23'd0);
      s1_zero    <= (in_op[30:0] == 31'd0);
    end
    if (s1_adv) begin
      s2_op      <= s1_op;
      s2_signed  <= s1_signed;
      s2_rm      <= s1_rm;
      s2_tag     <= s1_tag;
      s2_illegal <= s1_illegal;
      s2_nan     <= s1_nan;
      s2_inf     <= s1_inf;
      s2_zero    <= s1_zero;
    end
  end

  // Stage 2: converter interface
  assign conv_in        = s2_op;
  assign conv_is_signed = s2_signed;
  assign conv_rm        = s2_rm;

  logic        s2_sign;
  logic [7:0]  s2_exp;
  logic [22:0] s2_man;
  logic [22:0] frac_mask;
  logic        frac_nz;

  assign s2_sign = s2_op[31];
  assign s2_exp  = s2_op[30:23];
  assign s2_man  = s2_op[22:0];

  // Mantissa bits below the binary point for 127 <= exp < 150; values with
  // exp < 127 are below 1.0 and always have a fractional part.
  assign frac_mask = 23'h7F_FFFF >> (s2_exp - 8'd127);
  assign frac_nz   = (s2_exp < 8'd127) ||
                     ((s2_exp < 8'd150) && ((s2_man & frac_mask) != 23'd0));

  logic [31:0] res;
  logic        nv, nx;

  // NOTE: every signal written here gets a default first so no path leaves
  // it unassigned and no latch is inferred.
  always_comb begin
    res = conv_out;
    nv  = 1'b0;
    if (s2_illegal) begin
      res = 32'd0;
    end else if (s2_nan || (s2_inf && !s2_sign)) begin
      res = s2_signed ? 32'h7FFF_FFFF : 32'hFFFF_FFFF;
      nv  = 1'b1;
    end else if (s2_inf) begin
      res = s2_signed ? 32'h8000_0000 : 32'd0;
      nv  = 1'b1;
    end else if (s2_zero) begin
      res = 32'd0;
    end else if (s2_signed) begin
      // -2^31 is the only exactly representable value with exp >= 158; a
      // positive value rounding up to 2^31 shows up as 8000_0000 from the
      // converter.
      if ((s2_exp >= 8'd158 && s2_op != 32'hCF00_0000) ||
          (!s2_sign && conv_out == 32'h8000_0000)) begin
        res = s2_sign ? 32'h8000_0000 : 32'h7FFF_FFFF;
        nv  = 1'b1;
      end
    end else begin
      if (s2_exp >= 8'd159 || (s2_sign && conv_out != 32'd0)) begin
        res = s2_sign ? 32'd0 : 32'hFFFF_FFFF;
        nv  = 1'b1;
      end else if (s2_sign) begin
        res = 32'd0;
      end
    end
  end

  assign nx = ~nv & ~s2_illegal & ~s2_zero & frac_nz;

  // Outputs read as zero whenever no result is held (including in reset).
  assign out_valid   = s2_valid;
  assign out_result  = s2_valid ? res : 32'd0;
  assign out_tag     = s2_valid ? s2_tag : '0;
  assign out_fflags  = s2_valid ? {nv, 3'b000, nx} : 5'd0;
  assign out_illegal = s2_valid & s2_illegal;

endmodule

// File: tb/tb_fpu_cvt_f2i_pipe.sv
module tb_fpu_cvt_f2i_pipe;
  localparam int TAG_W = 5;

  logic             clock, reset_n;
  logic             in_valid, in_ready, in_is_signed;
  logic [31:0]      in_op;
  logic [2:0]       in_rm, frm;
  logic [TAG_W-1:0] in_tag;
  logic [31:0]      conv_in, conv_out;
  logic             conv_is_signed;
  logic [2:0]       conv_rm;
  logic             out_valid, out_ready, out_illegal;
  logic [31:0]      out_result;
  logic [TAG_W-1:0] out_tag;
  logic [4:0]       out_fflags;

  fpu_cvt_f2i_pipe #(.TAG_W(TAG_W)) dut (
    .clock(clock), .reset_n(reset_n),
    .in_valid(in_valid), .in_ready(in_ready), .in_op(in_op),
    .in_is_signed(in_is_signed), .in_rm(in_rm), .in_tag(in_tag), .frm(frm),
    .conv_in(conv_in), .conv_is_signed(conv_is_signed), .conv_rm(conv_rm),
    .conv_out(conv_out),
    .out_valid(out_valid), .out_ready(out_ready), .out_result(out_result),
    .out_tag(out_tag), .out_fflags(out_fflags), .out_illegal(out_illegal)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  typedef struct packed {
    logic [31:0]      res;
    logic [TAG_W-1:0] tag;
    logic [4:0]       flags;
    logic             ill;
  } exp_t;

  exp_t             sb_q[$];
  int               n_cmp  = 0;
  int               n_fail = 0;
  int               stall_cnt = 0;
  int               bp_mode   = 0;   // 0: always ready, 1: random
  logic [TAG_W-1:0] tag_cnt   = '0;

  localparam logic [4:0] F_NV = 5'b10000;
  localparam logic [4:0] F_NX = 5'b00001;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- reference arithmetic ----------------
  function automatic real op_value(input logic [31:0] op);
    int  ie;
    real mag;
    ie = int'(op[30:23]);
    if (ie == 0) mag = real'(op[22:0]) * (2.0 ** (-149));
    else         mag = (real'(op[22:0]) + 8388608.0) * (2.0 ** (ie - 150));
    return op[31] ? -mag : mag;
  endfunction

  // Round a real to an integral real under a RISC-V rounding mode.
  function automatic real rnd(input real v, input logic [2:0] rm);
    real fl, d;
    fl = $floor(v);
    d  = v - fl;
    case (rm)
      3'd0: begin
        if (d > 0.5)      return fl + 1.0;
        else if (d < 0.5) return fl;
        else              return ($floor(fl / 2.0) * 2.0 == fl) ? fl : fl + 1.0;
      end
      3'd1:    return (v >= 0.0) ? fl : $ceil(v);
      3'd2:    return fl;
      3'd3:    return $ceil(v);
      default: begin
        if (v >= 0.0) return (d >= 0.5) ? fl + 1.0 : fl;
        else          return (d > 0.5) ? fl + 1.0 : fl;
      end
    endcase
  endfunction

  // External converter: rounded value, low 32 bits of two's complement.
  function automatic logic [31:0] conv_model(input logic [31:0] op, input logic sgn,
                                             input logic [2:0] rm);
    real    r;
    longint li;
    if (op[30:23] == 8'hFF || rm > 3'd4) return 32'd0;
    r = rnd(op_value(op), rm);
    if (r > 9.0e18 || r < -9.0e18) return 32'd0;
    if (!sgn && r > 4294967295.0) return 32'hFFFF_FFFF;
    li = longint'(r);
    return li[31:0];
  endfunction

  always_comb conv_out = conv_model(conv_in, conv_is_signed, conv_rm);

  // Architectural result: round exactly, then range-check against the target.
  function automatic exp_t ref_model(input logic [31:0] op, input logic sgn,
                                     input logic [2:0] rm, input logic [2:0] f,
                                     input logic [TAG_W-1:0] tag);
    exp_t       e;
    logic [2:0] rme;
    real        v, r, lo, hi;
    longint     li;
    e.tag = tag; e.res = 32'd0; e.flags = 5'd0; e.ill = 1'b0;
    rme = (rm == 3'b111) ? f : rm;
    if (rme > 3'd4) begin
      e.ill = 1'b1;
      return e;
    end
    if (op[30:23] == 8'hFF) begin
      e.flags = F_NV;
      if (op[22:0] != 0 || !op[31]) e.res = sgn ? 32'h7FFF_FFFF : 32'hFFFF_FFFF;
      else                          e.res = sgn ? 32'h8000_0000 : 32'd0;
      return e;
    end
    v  = op_value(op);
    r  = rnd(v, rme);
    lo = sgn ? -2147483648.0 : 0.0;
    hi = sgn ? 2147483647.0 : 4294967295.0;
    if (r < lo || r > hi) begin
      e.flags = F_NV;
      if (op[31]) e.res = sgn ? 32'h8000_0000 : 32'd0;
      else        e.res = sgn ? 32'h7FFF_FFFF : 32'hFFFF_FFFF;
    end else begin
      li      = longint'(r);
      e.res   = li[31:0];
      e.flags = (r != v) ? F_NX : 5'd0;
    end
    return e;
  endfunction

  function automatic logic [31:0] rand_op();
    logic [31:0] op;
    logic [31:0] specials [9] = '{32'h0000_0000, 32'h8000_0000, 32'h7F80_0000,
                                  32'hFF80_0000, 32'h7FC0_0000, 32'hFF80_0001,
                                  32'hCF00_0000, 32'h4F00_0000, 32'h0000_0001};
    op = $urandom();
    case ($urandom_range(0, 4))
      0: ;
      1: op[30:23] = 8'($urandom_range(120, 165));
      2: begin
        op[30:23] = 8'($urandom_range(124, 152));
        if ($urandom_range(0, 1) == 1) op[11:0] = '0;
      end
      3: op = specials[$urandom_range(0, 8)];
      default: op[30:23] = 8'($urandom_range(126, 160));
    endcase
    return op;
  endfunction

  // ---------------- drivers ----------------
  function automatic logic exp_ready();
    return !(sb_q.size() == 2 && !out_ready);
  endfunction

  // Called just after a falling edge; returns just after the falling edge
  // that follows the accepting rising edge.
  task automatic send(input logic [31:0] op, input logic sgn, input logic [2:0] rm,
                      input logic [2:0] f, input exp_t e);
    int waited = 0;
    in_valid = 1'b1; in_op = op; in_is_signed = sgn; in_rm = rm; frm = f; in_tag = e.tag;
    forever begin
      #1;
      check("in_ready", in_ready, exp_ready());
      if (in_ready) begin
        sb_q.push_back(e);
        @(negedge clock);
        break;
      end
      waited++;
      if (waited > 50) begin
        n_cmp++; n_fail++;
        $display("FAIL accept_timeout: in_ready stayed 0, expected 1 within 50 cycles");
        @(negedge clock);
        break;
      end
      @(negedge clock);
    end
    in_valid = 1'b0;
    tag_cnt++;
  endtask

  task automatic send_ref(input logic [31:0] op, input logic sgn, input logic [2:0] rm,
                          input logic [2:0] f);
    send(op, sgn, rm, f, ref_model(op, sgn, rm, f, tag_cnt));
  endtask

  task automatic send_exp(input logic [31:0] op, input logic sgn, input logic [2:0] rm,
                          input logic [2:0] f, input logic [31:0] res,
                          input logic [4:0] flags, input logic ill);
    exp_t e;
    e.res = res; e.tag = tag_cnt; e.flags = flags; e.ill = ill;
    send(op, sgn, rm, f, e);
  endtask

  task automatic idle(input int n);
    in_valid = 1'b0;
    repeat (n) begin
      #1;
      check("in_ready_idle", in_ready, exp_ready());
      @(negedge clock);
    end
  endtask

  // After a send into an empty pipe: not valid one cycle on, valid the next.
  task automatic latency_probe();
    #1 check("lat_cycle1_out_valid", out_valid, 1'b0);
    @(negedge clock);
    #1 check("lat_cycle2_out_valid", out_valid, 1'b1);
    @(negedge clock);
  endtask

  // ---------------- downstream ready ----------------
  initial begin
    out_ready = 1'b1;
    forever begin
      @(negedge clock);
      if (stall_cnt > 0) begin
        out_ready = 1'b0;
        stall_cnt--;
      end else if (bp_mode == 1) begin
        out_ready = ($urandom_range(0, 9) < 7);
      end else begin
        out_ready = 1'b1;
      end
    end
  end

  // ---------------- monitor / scoreboard ----------------
  initial begin
    logic        hold;
    logic [31:0] h_res;
    logic [TAG_W-1:0] h_tag;
    logic [4:0]  h_flags;
    logic        h_ill;
    exp_t        e;
    hold = 1'b0;
    forever begin
      @(negedge clock);
      #2;
      if (!reset_n) begin
        hold = 1'b0;
        continue;
      end
      if (hold) begin
        check("hold_out_valid", out_valid, 1'b1);
        check("hold_out_result", out_result, h_res);
        check("hold_out_tag", out_tag, h_tag);
        check("hold_out_fflags", out_fflags, h_flags);
        check("hold_out_illegal", out_illegal, h_ill);
      end
      hold = 1'b0;
      if (out_valid && sb_q.size() == 0) begin
        check("spurious_out_valid", out_valid, 1'b0);
      end else if (out_valid && out_ready) begin
        e = sb_q.pop_front();
        check("out_result", out_result, e.res);
        check("out_tag", out_tag, e.tag);
        check("out_fflags", out_fflags, e.flags);
        check("out_illegal", out_illegal, e.ill);
      end else if (out_valid) begin
        hold = 1'b1;
        h_res = out_result; h_tag = out_tag; h_flags = out_fflags; h_ill = out_illegal;
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation still running at %0t, expected completion", $time);
    $fatal(1, "watchdog");
  end

  // ---------------- main sequence ----------------
  initial begin
    reset_n = 1'b0; in_valid = 1'b0; in_op = '0; in_is_signed = 1'b0;
    in_rm = '0; in_tag = '0; frm = '0;
    @(negedge clock);
    @(negedge clock);
    #1;
    check("rst_out_valid", out_valid, 1'b0);
    check("rst_in_ready", in_ready, 1'b1);
    check("rst_out_result", out_result, 32'd0);
    check("rst_out_tag", out_tag, '0);
    check("rst_out_fflags", out_fflags, 5'd0);
    check("rst_out_illegal", out_illegal, 1'b0);
    @(negedge clock);
    reset_n = 1'b1;
    @(negedge clock);

    // 1.5 signed RNE -> 2 NX, with latency check
    send_exp(32'h3FC0_0000, 1'b1, 3'b000, 3'b000, 32'd2, F_NX, 1'b0);
    latency_probe();
    // dynamic rm
    send_exp(32'h3FC0_0000, 1'b1, 3'b111, 3'b001, 32'd1, F_NX, 1'b0);
    send_exp(32'h3FC0_0000, 1'b1, 3'b111, 3'b101, 32'd0, 5'd0, 1'b1);
    send_exp(32'h3FC0_0000, 1'b0, 3'b110, 3'b000, 32'd0, 5'd0, 1'b1);
    send_exp(32'h3FC0_0000, 1'b0, 3'b111, 3'b111, 32'd0, 5'd0, 1'b1);
    // specials and range edges
    send_exp(32'h7FC0_0000, 1'b1, 3'b000, 3'b000, 32'h7FFF_FFFF, F_NV, 1'b0);
    send_exp(32'h7FC0_0000, 1'b0, 3'b000, 3'b000, 32'hFFFF_FFFF, F_NV, 1'b0);
    send_exp(32'hCF00_0000, 1'b1, 3'b000, 3'b000, 32'h8000_0000, 5'd0, 1'b0);
    send_exp(32'h4F00_0000, 1'b1, 3'b000, 3'b000, 32'h7FFF_FFFF, F_NV, 1'b0);
    send_exp(32'h4F00_0000, 1'b0, 3'b000, 3'b000, 32'h8000_0000, 5'd0, 1'b0);
    send_exp(32'h4F7F_FFFF, 1'b0, 3'b001, 3'b000, 32'hFFFF_FF00, 5'd0, 1'b0);
    send_exp(32'h4F80_0000, 1'b0, 3'b000, 3'b000, 32'hFFFF_FFFF, F_NV, 1'b0);
    send_exp(32'hFF80_0000, 1'b1, 3'b000, 3'b000, 32'h8000_0000, F_NV, 1'b0);
    send_exp(32'hFF80_0000, 1'b0, 3'b000, 3'b000, 32'd0, F_NV, 1'b0);
    send_exp(32'h7F80_0000, 1'b0, 3'b000, 3'b000, 32'hFFFF_FFFF, F_NV, 1'b0);
    send_exp(32'h8000_0000, 1'b0, 3'b000, 3'b000, 32'd0, 5'd0, 1'b0);
    // -0.5 unsigned: RDN -> -1 invalid, RNE -> 0 inexact
    send_exp(32'hBF00_0000, 1'b0, 3'b010, 3'b000, 32'd0, F_NV, 1'b0);
    send_exp(32'hBF00_0000, 1'b0, 3'b000, 3'b000, 32'd0, F_NX, 1'b0);
    idle(3);

    // 8 back-to-back with a 3-cycle downstream stall in the middle
    for (int i = 0; i < 8; i++) begin
      if (i == 3) stall_cnt = 3;
      send_ref(rand_op(), 1'($urandom_range(0, 1)), 3'($urandom_range(0, 4)), 3'd0);
    end
    idle(4);

    // Reset with both stages occupied
    stall_cnt = 1000;
    send_ref(32'h4120_0000, 1'b1, 3'b000, 3'b000);
    send_ref(32'h4130_0000, 1'b1, 3'b000, 3'b000);
    #3;
    reset_n = 1'b0;
    #1;
    check("midrst_out_valid", out_valid, 1'b0);
    check("midrst_in_ready", in_ready, 1'b1);
    sb_q.delete();
    stall_cnt = 0;
    @(negedge clock);
    #3 reset_n = 1'b1;
    @(negedge clock);
    send_exp(32'h40A0_0000, 1'b1, 3'b000, 3'b000, 32'd5, 5'd0, 1'b0);
    latency_probe();
    idle(3);
    #1 check("post_rst_alone", out_valid, 1'b0);
    @(negedge clock);

    // Randomized traffic with random backpressure
    bp_mode = 1;
    repeat (400) begin
      if ($urandom_range(0, 3) == 0) idle(1);
      send_ref(rand_op(), 1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)),
               3'($urandom_range(0, 7)));
    end
    bp_mode = 0;
    idle(1);
    for (int i = 0; i < 100 && sb_q.size() != 0; i++) @(negedge clock);
    if (sb_q.size() != 0) begin
      n_cmp++; n_fail++;
      $display("FAIL drain_timeout: %0d results outstanding, expected 0", sb_q.size());
    end
    @(negedge clock);
    #1 check("final_out_valid", out_valid, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
